avalon_mem_master: RTL and testbench

Responder side of the core's start/done memory handshake. It accepts one load/store request per start pulse from the RISC-V pipeline, executes it as a single Avalon-MM master transfer, and pulses done, with formatted read data for loads. The pipeline enable controller holds stage enables low between start and done. Two instances are used: instruction fetch (loads only) and external data port.

---
 rtl/avm_pkg.sv | 19 +
 rtl/avm_lane_align.sv | 50 +++++
 rtl/avalon_mem_master.sv | 199 +++++++++++++++++++
 tb/tb_avalon_mem_master.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/avm_pkg.sv
// rtl/avm_pkg.sv - shared state encoding and access-size codes for the Avalon memory master
package avm_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2,
        DONE = 2'd3
    } avm_state_e;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    function automatic logic size_illegal(input logic [1:0] size);
        return (size != SZ_B) && (size != SZ_H) && (size != SZ_W);
    endfunction

endpackage

// File: rtl/avm_lane_align.sv
// rtl/avm_lane_align.sv - byte-lane steering for stores and extraction/extension for loads
module avm_lane_align
    import avm_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic [1:0]  off_i,
    input  logic        unsigned_ld_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] readdata_i,
    output logic [3:0]  byteenable_o,
    output logic [31:0] writedata_o,
    output logic [31:0] rdata_o,
    output logic        misalign_o
);

    logic [31:0] shifted;

    always_comb begin
        shifted      = readdata_i >> {off_i, 3'b000};
        byteenable_o = 4'b0000;
        writedata_o  = wdata_i;
        rdata_o      = shifted;
        misalign_o   = 1'b0;
        case (size_i)
            SZ_B: begin
                byteenable_o = 4'b0001 << off_i;
                writedata_o  = {4{wdata_i[7:0]}};
                rdata_o      = unsigned_ld_i ? {24'd0, shifted[7:0]}
                                             : {{24{shifted[7]}}, shifted[7:0]};
            end
            SZ_H: begin
                byteenable_o = 4'b0011 << off_i;
                writedata_o  = {2{wdata_i[15:0]}};
                rdata_o      = unsigned_ld_i ? {16'd0, shifted[15:0]}
                                             : {{16{shifted[15]}}, shifted[15:0]};
                misalign_o   = off_i[0];
            end
            SZ_W: begin
                byteenable_o = 4'b1111;
                writedata_o  = wdata_i;
                rdata_o      = readdata_i;
                misalign_o   = (off_i != 2'b00);
            end
            default: begin
                byteenable_o = 4'b0000;
            end
        endcase
    end

endmodule

// File: rtl/avalon_mem_master.sv
// rtl/avalon_mem_master.sv - start/done load/store responder issuing one Avalon-MM transfer per request
module avalon_mem_master
    import avm_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 1023,
    parameter int CNT_W   = 10
)
(
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              start,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [1:0]        size,
    input  logic              unsigned_ld,
    input  logic [DATA_W-1:0] wdata,
    output logic              done,
    output logic [DATA_W-1:0] rdata,
    output logic              err,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_read,
    output logic              avm_write,
    output logic [3:0]        avm_byteenable,
    output logic [DATA_W-1:0] avm_writedata,
    input  logic [DATA_W-1:0] avm_readdata,
    input  logic              avm_waitrequest,
    input  logic              avm_readdatavalid
);

    localparam bit             TMO_EN   = (TIMEOUT > 0);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    avm_state_e        state_q, state_d;
    logic              we_q, we_d;
    logic [1:0]        size_q, size_d;
    logic [1:0]        off_q, off_d;
    logic              uns_q, uns_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              rd_q, rd_d;
    logic              wr_q, wr_d;
    logic [3:0]        be_q, be_d;
    logic [DATA_W-1:0] wd_q, wd_d;

    logic [1:0]        al_size;
    logic [1:0]        al_off;
    logic              al_uns;
    logic [3:0]        al_be;
    logic [31:0]       al_wd;
    logic [31:0]       al_rd;
    logic              al_misalign;
    logic              tmo_hit;

    // In IDLE the aligner looks at the live request; afterwards at the latched one.
    assign al_size = (state_q == IDLE) ? size        : size_q;
    assign al_off  = (state_q == IDLE) ? addr[1:0]   : off_q;
    assign al_uns  = (state_q == IDLE) ? unsigned_ld : uns_q;

    avm_lane_align u_align (
        .size_i        (al_size),
        .off_i         (al_off),
        .unsigned_ld_i (al_uns),
        .wdata_i       (wdata),
        .readdata_i    (avm_readdata),
        .byteenable_o  (al_be),
        .writedata_o   (al_wd),
        .rdata_o       (al_rd),
        .misalign_o    (al_misalign)
    );

    assign tmo_hit = TMO_EN && (cnt_q == TMO_LAST);

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        size_d  = size_q;
        off_d   = off_q;
        uns_d   = uns_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        rdata_d = rdata_q;
        addr_d  = addr_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        be_d    = be_q;
        wd_d    = wd_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    we_d   = we;
                    size_d = size;
                    off_d  = addr[1:0];
                    uns_d  = unsigned_ld;
                    if (al_misalign || size_illegal(size)) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                    end else begin
                        state_d = REQ;
                        cnt_d   = '0;
                        rd_d    = ~we;
                        wr_d    = we;
                        addr_d  = {addr[ADDR_W-1:2], 2'b00};
                        be_d    = al_be;
                        wd_d    = al_wd;
                    end
                end
            end
            REQ: begin
                cnt_d = cnt_q + 1'b1;
                // A normal acceptance wins over a timeout landing in the same cycle.
                if (!avm_waitrequest) begin
                    rd_d = 1'b0;
                    wr_d = 1'b0;
                    if (we_q) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = RESP;
                    end
                end else if (tmo_hit) begin
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    state_d = DONE;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                end
            end
            RESP: begin
                cnt_d = cnt_q + 1'b1;
                if (avm_readdatavalid) begin
                    rdata_d = al_rd;
                    state_d = DONE;
                    done_d  = 1'b1;
                end else if (tmo_hit) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            size_q  <= SZ_B;
            off_q   <= 2'b00;
            uns_q   <= 1'b0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
            addr_q  <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            be_q    <= 4'b0000;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            size_q  <= size_d;
            off_q   <= off_d;
            uns_q   <= uns_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            addr_q  <= addr_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            be_q    <= be_d;
            wd_q    <= wd_d;
        end
    end

    assign done           = done_q;
    assign err            = err_q;
    assign rdata          = rdata_q;
    assign avm_address    = addr_q;
    assign avm_read       = rd_q;
    assign avm_write      = wr_q;
    assign avm_byteenable = be_q;
    assign avm_writedata  = wd_q;

endmodule

// File: tb/tb_avalon_mem_master.sv
// tb/tb_avalon_mem_master.sv - directed bench with a cycle-scheduled transaction model
module tb_avalon_mem_master;

    localparam int TOUT = 8;
    localparam int MAXC = 1024;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        start = 1'b0;
    logic        we = 1'b0;
    logic [31:0] addr = '0;
    logic [1:0]  size = '0;
    logic        unsigned_ld = 1'b0;
    logic [31:0] wdata = '0;
    logic        done;
    logic [31:0] rdata;
    logic        err;
    logic [31:0] avm_address;
    logic        avm_read;
    logic        avm_write;
    logic [3:0]  avm_byteenable;
    logic [31:0] avm_writedata;
    logic [31:0] avm_readdata = '0;
    logic        avm_waitrequest = 1'b0;
    logic        avm_readdatavalid = 1'b0;

    avalon_mem_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TOUT), .CNT_W(10)) dut (
        .CLK               (CLK),
        .RST_N             (RST_N),
        .start             (start),
        .we                (we),
        .addr              (addr),
        .size              (size),
        .unsigned_ld       (unsigned_ld),
        .wdata             (wdata),
        .done              (done),
        .rdata             (rdata),
        .err               (err),
        .avm_address       (avm_address),
        .avm_read          (avm_read),
        .avm_write         (avm_write),
        .avm_byteenable    (avm_byteenable),
        .avm_writedata     (avm_writedata),
        .avm_readdata      (avm_readdata),
        .avm_waitrequest   (avm_waitrequest),
        .avm_readdatavalid (avm_readdatavalid)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;
    bit chk_en = 1'b0;

    // Expected outputs, indexed by cycle number
    bit          exp_done [MAXC];
    bit          exp_err  [MAXC];
    bit          exp_rd   [MAXC];
    bit          exp_wr   [MAXC];
    logic [31:0] exp_addr [MAXC];
    logic [3:0]  exp_be   [MAXC];
    logic [31:0] exp_wd   [MAXC];
    logic [31:0] exp_rdat [MAXC];

    int          obs_cmd;
    int          obs_dk;
    logic        obs_err;
    logic [3:0]  obs_be;
    logic [31:0] obs_wd;
    logic [31:0] obs_addr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] fmt_load(input logic [31:0] rd, input int off,
                                             input logic [1:0] sz, input bit uns);
        logic [31:0] v;
        v = rd / (32'd1 << (8 * off));
        if (sz == 2'd0) return uns ? (v % 256) : ((v % 256) >= 128 ? (v % 256) + 32'hFFFFFF00 : v % 256);
        if (sz == 2'd1) return uns ? (v % 65536) : ((v % 65536) >= 32768 ? (v % 65536) + 32'hFFFF0000 : v % 65536);
        return rd;
    endfunction

    function automatic logic [31:0] lanes_wd(input logic [31:0] w, input logic [1:0] sz);
        if (sz == 2'd0) return (w % 256) * 32'h01010101;
        if (sz == 2'd1) return (w % 65536) * 32'h00010001;
        return w;
    endfunction

    function automatic logic [3:0] lanes_be(input int off, input logic [1:0] sz);
        if (sz == 2'd0) return 4'(1 << off);
        if (sz == 2'd1) return 4'(3 << off);
        return 4'hF;
    endfunction

    always @(negedge CLK) begin
        if (chk_en && cyc < MAXC) begin
            chk("done", {31'd0, done}, {31'd0, exp_done[cyc]});
            if (exp_done[cyc]) chk("err", {31'd0, err}, {31'd0, exp_err[cyc]});
            chk("avm_read", {31'd0, avm_read}, {31'd0, exp_rd[cyc]});
            chk("avm_write", {31'd0, avm_write}, {31'd0, exp_wr[cyc]});
            chk("rdata", rdata, exp_rdat[cyc]);
            if (exp_rd[cyc] || exp_wr[cyc]) begin
                chk("avm_address", avm_address, exp_addr[cyc]);
                chk("avm_byteenable", {28'd0, avm_byteenable}, {28'd0, exp_be[cyc]});
            end
            if (exp_wr[cyc]) chk("avm_writedata", avm_writedata, exp_wd[cyc]);
        end
    end

    // Entered and left just after a rising edge; rdv<0 means readdatavalid never comes.
    task automatic txn(input bit w, input logic [31:0] a, input logic [1:0] sz, input bit uns,
                       input logic [31:0] wd, input logic [31:0] bus_rd,
                       input int nwait, input int rdv);
        int  c, off, acc, fin, dn;
        bit  illegal, to;
        c = cyc;
        off = int'(a % 4);
        illegal = (sz == 2'd3) || (sz == 2'd1 && (a % 2) != 0) || (sz == 2'd2 && off != 0);
        if (illegal) begin
            dn = c + 1;
            to = 1'b1;
        end else begin
            acc = c + 1 + nwait;
            fin = w ? acc + 1 : (rdv < 0 ? c + 100000 : acc + 2 + rdv);
            to  = (TOUT != 0) && (fin - (c + 1) > TOUT);
            dn  = to ? c + 1 + TOUT : fin;
            for (int t = c + 1; t <= acc && t < dn; t++) begin
                exp_rd[t]   = ~w;
                exp_wr[t]   = w;
                exp_addr[t] = a - off;
                exp_be[t]   = lanes_be(off, sz);
                exp_wd[t]   = lanes_wd(wd, sz);
            end
            if (!w && !to)
                for (int t = dn; t < MAXC; t++) exp_rdat[t] = fmt_load(bus_rd, off, sz, uns);
        end
        exp_done[dn] = 1'b1;
        exp_err[dn]  = to;
        obs_cmd = 0; obs_dk = -1; obs_err = 1'b0;
        obs_be = '0; obs_wd = '0; obs_addr = '0;
        start = 1'b1; we = w; addr = a; size = sz; unsigned_ld = uns; wdata = wd;
        avm_readdata = bus_rd; avm_waitrequest = 1'b0; avm_readdatavalid = 1'b0;
        for (int k = 0; k <= dn - c; k++) begin
            if (k > 0) begin
                @(posedge CLK); #1;
                start = 1'b0;
                avm_waitrequest   = (k >= 1 && k <= nwait);
                avm_readdatavalid = (rdv >= 0 && k == nwait + 2 + rdv);
            end
            @(negedge CLK);
            if (avm_read || avm_write) begin
                obs_cmd++;
                obs_be = avm_byteenable; obs_wd = avm_writedata; obs_addr = avm_address;
            end
            if (done) begin
                obs_dk = k;
                obs_err = err;
            end
        end
        @(posedge CLK); #1;
        avm_waitrequest = 1'b0;
        avm_readdatavalid = 1'b0;
    endtask

    initial begin
        for (int t = 0; t < MAXC; t++) begin
            exp_done[t] = 0; exp_err[t] = 0; exp_rd[t] = 0; exp_wr[t] = 0;
            exp_addr[t] = '0; exp_be[t] = '0; exp_wd[t] = '0; exp_rdat[t] = '0;
        end
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_read", {31'd0, avm_read}, 32'd0);
        chk("rst_write", {31'd0, avm_write}, 32'd0);
        chk("rst_be", {28'd0, avm_byteenable}, 32'd0);
        chk("rst_addr", avm_address, 32'd0);
        chk("rst_wd", avm_writedata, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        RST_N = 1'b1;
        @(posedge CLK); #1;
        chk_en = 1'b1;

        txn(1, 32'h100, 2'd2, 0, 32'hDEADBEEF, 32'h0, 0, 0);
        chk("sw_done_k", obs_dk, 2);
        chk("sw_err", {31'd0, obs_err}, 32'd0);
        chk("sw_cmds", obs_cmd, 1);
        chk("sw_be", {28'd0, obs_be}, 32'hF);
        chk("sw_addr", obs_addr, 32'h100);

        txn(0, 32'h203, 2'd0, 0, 32'h0, 32'h80123456, 0, 0);
        chk("lb_done_k", obs_dk, 3);
        chk("lb_be", {28'd0, obs_be}, 32'h8);
        chk("lb_addr", obs_addr, 32'h200);
        chk("lb_rdata", rdata, 32'hFFFFFF80);
        txn(0, 32'h203, 2'd0, 1, 32'h0, 32'h80123456, 0, 0);
        chk("lbu_rdata", rdata, 32'h00000080);

        txn(1, 32'h12, 2'd1, 0, 32'h0000ABCD, 32'h0, 3, 0);
        chk("sh_cmds", obs_cmd, 4);
        chk("sh_done_k", obs_dk, 5);
        chk("sh_wd", obs_wd, 32'hABCDABCD);
        chk("sh_be", {28'd0, obs_be}, 32'hC);

        txn(1, 32'h7, 2'd0, 0, 32'h0000005A, 32'h0, 1, 0);
        chk("sb_wd", obs_wd, 32'h5A5A5A5A);
        chk("sb_be", {28'd0, obs_be}, 32'h8);

        txn(0, 32'h12, 2'd1, 0, 32'h0, 32'h87654321, 1, 2);
        chk("lh_rdata", rdata, 32'hFFFF8765);
        txn(0, 32'h12, 2'd1, 1, 32'h0, 32'h87654321, 0, 0);
        chk("lhu_rdata", rdata, 32'h00008765);
        txn(0, 32'h1, 2'd0, 0, 32'h0, 32'h0000AB00, 0, 0);
        chk("lb1_rdata", rdata, 32'hFFFFFFAB);
        txn(0, 32'h40, 2'd2, 0, 32'h0, 32'h12345678, 2, 1);
        chk("lw_rdata", rdata, 32'h12345678);

        txn(0, 32'h101, 2'd2, 0, 32'h0, 32'hFFFFFFFF, 0, 0);
        chk("mis_cmds", obs_cmd, 0);
        chk("mis_done_k", obs_dk, 1);
        chk("mis_err", {31'd0, obs_err}, 32'd1);
        chk("mis_rdata", rdata, 32'h12345678);
        txn(0, 32'h13, 2'd1, 0, 32'h0, 32'h0, 0, 0);
        chk("mish_err", {31'd0, obs_err}, 32'd1);
        txn(1, 32'h20, 2'd3, 0, 32'h1, 32'h0, 0, 0);
        chk("ill_cmds", obs_cmd, 0);
        chk("ill_err", {31'd0, obs_err}, 32'd1);

        txn(0, 32'h300, 2'd2, 0, 32'h0, 32'hCAFEF00D, 0, -1);
        chk("tor_done_k", obs_dk, 9);
        chk("tor_err", {31'd0, obs_err}, 32'd1);
        chk("tor_cmds", obs_cmd, 1);
        chk("tor_rdata", rdata, 32'h12345678);
        txn(1, 32'h304, 2'd2, 0, 32'h11223344, 32'h0, 20, 0);
        chk("tow_done_k", obs_dk, 9);
        chk("tow_cmds", obs_cmd, 8);

        avm_readdatavalid = 1'b1;
        @(posedge CLK); #1;
        avm_readdatavalid = 1'b0;
        @(posedge CLK); #1;

        chk_en = 1'b0;
        start = 1'b1; we = 1'b0; addr = 32'h400; size = 2'd2; avm_readdata = 32'h99;
        @(posedge CLK); #1;
        start = 1'b0;
        @(posedge CLK); #1;
        #2 RST_N = 1'b0;
        #1;
        chk("mrst_done", {31'd0, done}, 32'd0);
        chk("mrst_err", {31'd0, err}, 32'd0);
        chk("mrst_read", {31'd0, avm_read}, 32'd0);
        chk("mrst_write", {31'd0, avm_write}, 32'd0);
        chk("mrst_be", {28'd0, avm_byteenable}, 32'd0);
        chk("mrst_addr", avm_address, 32'd0);
        chk("mrst_wd", avm_writedata, 32'd0);
        chk("mrst_rdata", rdata, 32'd0);
        @(negedge CLK);
        RST_N = 1'b1;
        @(posedge CLK); #1;
        for (int t = cyc; t < MAXC; t++) exp_rdat[t] = '0;
        chk_en = 1'b1;
        avm_readdatavalid = 1'b1;
        @(negedge CLK);
        @(posedge CLK); #1;
        avm_readdatavalid = 1'b0;
        @(negedge CLK);
        chk("late_rdv_done", {31'd0, done}, 32'd0);
        @(posedge CLK); #1;

        txn(1, 32'h500, 2'd1, 0, 32'h00001234, 32'h0, 0, 0);
        chk("post_sw_k", obs_dk, 2);
        txn(0, 32'h502, 2'd1, 1, 32'h0, 32'hFEDC0000, 1, 0);
        chk("post_lh_rdata", rdata, 32'h0000FEDC);

        repeat (2) @(posedge CLK);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
